// File: rtl/mem_port_arbiter_if.sv
// Port bundle between the IF/MEM requesters, the arbiter and the unified
// instruction/data memory. The arbiter uses the slave view; the pipeline
// stages plus the memory macro sit on the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
) ();
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 1-cycle-latency synchronous memory between
// instruction fetch and the data port. Data port has fixed priority.
// Optional fetch anti-starvation is enabled by defining MEM_ARB_STARVE_EN.
// Pipeline: accept (t) -> memory command (t+1) -> read response (t+2).
module mem_port_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus,
  output logic [15:0]        conflict_cnt
);

  logic          force_if;
  logic          cmd_tag;
  logic          cmd_rd;
  logic          rsp_tag;
  logic          rsp_rd;
  logic [DW-1:0] if_hold;
  logic [DW-1:0] dm_hold;

`ifdef MEM_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIM + 1);
  logic [SW-1:0] starve_cnt;

  assign force_if = bus.if_req && (starve_cnt == SW'(STARVE_LIM));

  // Count consecutive denied fetch cycles; any fetch accept or idle fetch clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve_cnt <= '0;
    else if (!bus.if_req || bus.if_gnt)
      starve_cnt <= '0;
    else
      starve_cnt <= starve_cnt + SW'(1);
  end
`else
  assign force_if = 1'b0;
`endif

  // Grant: data port wins unless fetch has been starved long enough.
  always_comb begin
    bus.dm_gnt = bus.dm_req && !force_if;
    bus.if_gnt = bus.if_req && !bus.dm_gnt;
  end

  // Command stage: register the winning request toward the memory for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cmd_tag       <= 1'b0;
      cmd_rd        <= 1'b0;
    end else begin
      bus.mem_en    <= bus.if_gnt || bus.dm_gnt;
      bus.mem_we    <= bus.dm_gnt && bus.dm_we;
      bus.mem_addr  <= bus.dm_gnt ? bus.dm_addr : bus.if_addr;
      bus.mem_wdata <= bus.dm_gnt ? bus.dm_wdata : '0;
      cmd_tag       <= bus.dm_gnt;
      cmd_rd        <= bus.if_gnt || (bus.dm_gnt && !bus.dm_we);
    end
  end

  // Response stage: tag follows the read into the cycle its data appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_tag <= 1'b0;
      rsp_rd  <= 1'b0;
    end else begin
      rsp_tag <= cmd_tag;
      rsp_rd  <= cmd_rd;
    end
  end

  assign bus.if_rvalid = rsp_rd && !rsp_tag;
  assign bus.dm_rvalid = rsp_rd &&  rsp_tag;

  // Memory output is only valid for one cycle, so keep a copy per port to
  // hold the last delivered word afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_hold <= '0;
      dm_hold <= '0;
    end else begin
      if (bus.if_rvalid) if_hold <= bus.mem_rdata;
      if (bus.dm_rvalid) dm_hold <= bus.mem_rdata;
    end
  end

  assign bus.if_rdata = bus.if_rvalid ? bus.mem_rdata : if_hold;
  assign bus.dm_rdata = bus.dm_rvalid ? bus.mem_rdata : dm_hold;

  // Saturating count of cycles where both ports asked for the memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      conflict_cnt <= '0;
    else if (bus.if_req && bus.dm_req && conflict_cnt != 16'hFFFF)
      conflict_cnt <= conflict_cnt + 16'd1;
  end

endmodule
